// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope capture path (trigger stage and FIFO blocks).
package osc_pkg;

   localparam int DATA_SIZE_DEF = 4;
   localparam int ADDR_SIZE_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/trig_edge_detect.sv
// Threshold-crossing detector: remembers the previous valid sample while enabled
// and flags a rising (or, when falling_i is set, falling) crossing of threshold_i.
module trig_edge_detect #(
   parameter int DATA_SIZE = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic [DATA_SIZE-1:0] sample_i,
   input  logic                 sample_valid_i,
   input  logic [DATA_SIZE-1:0] threshold_i,
   input  logic                 falling_i,
   output logic                 trigger_o
);

   logic [DATA_SIZE-1:0] prev;
   logic                 prev_valid;
   logic                 rise_hit;
   logic                 fall_hit;

   // Track the previous valid sample; a clear makes the next sample a fresh start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (clear_i) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (enable_i && sample_valid_i) begin
         prev       <= sample_i;
         prev_valid <= 1'b1;
      end
   end

   assign rise_hit  = (prev < threshold_i) && (sample_i >= threshold_i);
   assign fall_hit  = (prev >= threshold_i) && (sample_i < threshold_i);
   assign trigger_o = enable_i && sample_valid_i && prev_valid &&
                      (falling_i ? fall_hit : rise_hit);

endmodule

// File: rtl/trigger_capture.sv
// Trigger and capture front end of the sample FIFO: waits for a threshold crossing,
// then writes CAPTURE_LEN decimated samples into the FIFO write port.
// Optional feature macro TRIG_SLOPE_EN adds trig_falling_i for falling-edge triggers.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | nothing in progress, waiting for arm_i
//   ARMED   | watching the sample stream for a threshold crossing
//   CAPTURE | keeping 1 of every decim+1 samples until the record is full
//   DONE    | record complete, waiting for a re-arm
module trigger_capture
   import osc_pkg::*;
#(
   parameter int DATA_SIZE   = DATA_SIZE_DEF,
   parameter int CAPTURE_LEN = 8,
   parameter int DECIM_W     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DATA_SIZE-1:0] sample_i,
   input  logic                 sample_valid_i,
   input  logic [DATA_SIZE-1:0] threshold_i,
   input  logic [DECIM_W-1:0]   decim_i,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic                 fifo_full_i,
`ifdef TRIG_SLOPE_EN
   input  logic                 trig_falling_i,
`endif
   output logic [DATA_SIZE-1:0] w_data_o,
   output logic                 w_inc_o,
   output logic                 armed_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overflow_o
);

   localparam int LEN_W = $clog2(CAPTURE_LEN + 1);

   state_t             state;
   state_t             next_state;
   logic [DECIM_W-1:0] decim_cnt;
   logic [DECIM_W-1:0] decim_hold;
   logic [LEN_W-1:0]   len_cnt;
   logic [LEN_W-1:0]   len_inc;
   logic               keep;
   logic               arm_enter;
   logic               trigger;
   logic               falling_sel;

`ifdef TRIG_SLOPE_EN
   logic falling_q;

   // Slope selection is latched when the trigger is armed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)          falling_q <= 1'b0;
      else if (arm_enter) falling_q <= trig_falling_i;
   end

   assign falling_sel = falling_q;
`else
   assign falling_sel = 1'b0;
`endif

   trig_edge_detect #(
      .DATA_SIZE (DATA_SIZE)
   ) u_edge (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_i        (arm_enter),
      .enable_i       (state == ARMED),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .threshold_i    (threshold_i),
      .falling_i      (falling_sel),
      .trigger_o      (trigger)
   );

   assign len_inc = len_cnt + LEN_W'(1);

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   // Next state and the keep decision; abort overrides everything, including a pending write.
   always_comb begin
      next_state = state;
      keep       = 1'b0;
      arm_enter  = 1'b0;
      case (state)
         IDLE:    if (arm_i) next_state = ARMED;
         ARMED:   if (trigger) begin
                     keep       = 1'b1;
                     next_state = CAPTURE;
                  end
         CAPTURE: if (sample_valid_i && (decim_cnt == '0)) keep = 1'b1;
         DONE:    if (arm_i) next_state = ARMED;
         default: next_state = IDLE;
      endcase
      if (keep && (len_inc == LEN_W'(CAPTURE_LEN))) next_state = DONE;
      if (abort_i) begin
         next_state = IDLE;
         keep       = 1'b0;
      end
      arm_enter = (next_state == ARMED) && (state != ARMED);
   end

   // Write register, counters and sticky overflow; a dropped sample still counts toward the record.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_inc_o    <= 1'b0;
         w_data_o   <= '0;
         overflow_o <= 1'b0;
         decim_cnt  <= '0;
         decim_hold <= '0;
         len_cnt    <= '0;
      end else begin
         w_inc_o <= keep && !fifo_full_i;
         if (keep && !fifo_full_i) w_data_o <= sample_i;
         if (arm_enter) begin
            overflow_o <= 1'b0;
            decim_cnt  <= '0;
            len_cnt    <= '0;
         end else begin
            if (keep) begin
               len_cnt <= len_inc;
               if (fifo_full_i) overflow_o <= 1'b1;
            end
            if ((state == ARMED) && keep) begin
               decim_hold <= decim_i;
               decim_cnt  <= (decim_i == '0) ? '0 : DECIM_W'(1);
            end else if ((state == CAPTURE) && sample_valid_i) begin
               decim_cnt  <= (decim_cnt == decim_hold) ? '0 : decim_cnt + DECIM_W'(1);
            end
         end
      end
   end

   assign armed_o = (state == ARMED);
   assign busy_o  = (state == CAPTURE);
   assign done_o  = (state == DONE);

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: a vector table for the basic rising-trigger
// record, then hand-written sequences for the multi-cycle corner cases.
module tb_trigger_capture;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic [3:0] sample = '0;
   logic       valid  = 1'b0;
   logic [3:0] thr    = 4'd8;
   logic [3:0] decim  = '0;
   logic       arm    = 1'b0;
   logic       abort  = 1'b0;
   logic       full   = 1'b0;
`ifdef TRIG_SLOPE_EN
   logic       falling = 1'b0;
`endif
   logic [3:0] w_data;
   logic       w_inc;
   logic       armed;
   logic       busy;
   logic       done;
   logic       ovf;

   int n_vec = 0;
   int n_mis = 0;
   logic [3:0] wq[$];

   always #5 clk = ~clk;

   trigger_capture #(
      .DATA_SIZE   (4),
      .CAPTURE_LEN (8),
      .DECIM_W     (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .sample_i       (sample),
      .sample_valid_i (valid),
      .threshold_i    (thr),
      .decim_i        (decim),
      .arm_i          (arm),
      .abort_i        (abort),
      .fifo_full_i    (full),
`ifdef TRIG_SLOPE_EN
      .trig_falling_i (falling),
`endif
      .w_data_o       (w_data),
      .w_inc_o        (w_inc),
      .armed_o        (armed),
      .busy_o         (busy),
      .done_o         (done),
      .overflow_o     (ovf)
   );

   typedef struct {
      logic       r;
      logic       a;
      logic       ab;
      logic       v;
      logic [3:0] s;
      logic       e_inc;
      logic [3:0] e_data;
      logic [2:0] e_stat;   // {done, busy, armed}
      logic       e_ovf;
   } vec_t;

   function automatic vec_t mk(logic r, logic a, logic ab, logic v, logic [3:0] s,
                               logic ei, logic [3:0] ed, logic [2:0] es, logic eo);
      vec_t t;
      t.r = r; t.a = a; t.ab = ab; t.v = v; t.s = s;
      t.e_inc = ei; t.e_data = ed; t.e_stat = es; t.e_ovf = eo;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic a, input logic ab, input logic v,
                       input logic [3:0] s, input logic f);
      @(negedge clk);
      arm = a; abort = ab; valid = v; sample = s; full = f;
      @(posedge clk);
      #1;
      if (w_inc) wq.push_back(w_data);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; arm = 1'b0; abort = 1'b0; valid = 1'b0; full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[16];

   initial begin
      // Rising trigger at threshold 8, decim 0: 9 triggers, 8 writes, then DONE.
      tbl[0]  = mk(1, 0, 0, 0, 4'd0,  0, 4'd0,  3'b000, 0);
      tbl[1]  = mk(0, 0, 0, 0, 4'd0,  0, 4'd0,  3'b000, 0);
      tbl[2]  = mk(0, 1, 0, 0, 4'd0,  0, 4'd0,  3'b001, 0);
      tbl[3]  = mk(0, 0, 0, 1, 4'd2,  0, 4'd0,  3'b001, 0);
      tbl[4]  = mk(0, 0, 0, 1, 4'd5,  0, 4'd0,  3'b001, 0);
      tbl[5]  = mk(0, 0, 0, 1, 4'd7,  0, 4'd0,  3'b001, 0);
      tbl[6]  = mk(0, 0, 0, 1, 4'd9,  1, 4'd9,  3'b010, 0);
      tbl[7]  = mk(0, 0, 0, 1, 4'd10, 1, 4'd10, 3'b010, 0);
      tbl[8]  = mk(0, 0, 0, 1, 4'd11, 1, 4'd11, 3'b010, 0);
      tbl[9]  = mk(0, 0, 0, 1, 4'd12, 1, 4'd12, 3'b010, 0);
      tbl[10] = mk(0, 0, 0, 1, 4'd13, 1, 4'd13, 3'b010, 0);
      tbl[11] = mk(0, 0, 0, 1, 4'd14, 1, 4'd14, 3'b010, 0);
      tbl[12] = mk(0, 0, 0, 1, 4'd15, 1, 4'd15, 3'b010, 0);
      tbl[13] = mk(0, 0, 0, 1, 4'd0,  1, 4'd0,  3'b100, 0);
      tbl[14] = mk(0, 0, 0, 1, 4'd1,  0, 4'd0,  3'b100, 0);
      tbl[15] = mk(0, 1, 0, 0, 4'd0,  0, 4'd0,  3'b001, 0);

      thr = 4'd8; decim = 4'd0; full = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rst = tbl[i].r; arm = tbl[i].a; abort = tbl[i].ab;
         valid = tbl[i].v; sample = tbl[i].s;
         @(posedge clk);
         #1;
         n_vec++;
         if ({w_inc, w_data, done, busy, armed, ovf} !==
             {tbl[i].e_inc, tbl[i].e_data, tbl[i].e_stat, tbl[i].e_ovf}) begin
            n_mis++;
            $display("FAIL vec%0d: got inc=%b data=%0d stat=%b ovf=%b, expected inc=%b data=%0d stat=%b ovf=%b",
                     i, w_inc, w_data, {done, busy, armed}, ovf,
                     tbl[i].e_inc, tbl[i].e_data, tbl[i].e_stat, tbl[i].e_ovf);
         end
      end

      // Decimation 2 on a wrapping ramp, threshold 4; decim_i changed after the trigger must not matter.
      do_reset();
      thr = 4'd4; decim = 4'd2;
      step(1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 60 && !done; i++) begin
         step(0, 0, 1, 4'(i), 0);
         if (i == 4) decim = 4'd0;
      end
      chk("decim_write_count", wq.size(), 8);
      chk("decim_done", done, 1);
      for (int k = 0; k < 8 && k < wq.size(); k++)
         chk($sformatf("decim_write%0d", k), wq[k], (4 + 3 * k) % 16);

      // Overflow: FIFO full for the 2nd and 3rd kept samples.
      do_reset();
      thr = 4'd8; decim = 4'd0;
      step(1, 0, 0, 4'd0, 0);
      begin
         logic [3:0] ov_s [10];
         logic       ov_f [10];
         ov_s = '{4'd2, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
         ov_f = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
         for (int i = 0; i < 10; i++) step(0, 0, 1, ov_s[i], ov_f[i]);
      end
      chk("ovf_write_count", wq.size(), 6);
      if (wq.size() >= 2) chk("ovf_second_write", wq[1], 12);
      chk("ovf_flag", ovf, 1);
      chk("ovf_done", done, 1);
      step(1, 0, 0, 4'd0, 0);
      chk("rearm_clears_ovf", ovf, 0);
      chk("rearm_armed", armed, 1);

      // First sample already above threshold never triggers; a later 3 -> 9 does. Then abort.
      do_reset();
      thr = 4'd8;
      step(1, 0, 0, 4'd0, 0);
      step(0, 0, 1, 4'd9, 0);
      step(0, 0, 1, 4'd10, 0);
      step(0, 0, 1, 4'd12, 0);
      chk("notrig_armed", armed, 1);
      chk("notrig_writes", wq.size(), 0);
      step(0, 0, 1, 4'd3, 0);
      chk("notrig_still_armed", armed, 1);
      step(0, 0, 1, 4'd9, 0);
      chk("retrig_busy", busy, 1);
      chk("retrig_inc", w_inc, 1);
      chk("retrig_data", w_data, 9);
      step(0, 0, 1, 4'd10, 0);
      step(0, 0, 1, 4'd11, 0);
      chk("abort_pre_writes", wq.size(), 3);
      step(0, 1, 1, 4'd12, 0);
      chk("abort_status", {done, busy, armed}, 0);
      chk("abort_inc", w_inc, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(13 + i), 0);
      chk("abort_no_more_writes", wq.size(), 3);
      step(1, 1, 0, 4'd0, 0);
      chk("arm_abort_same_cycle", {done, busy, armed}, 0);

      // Asynchronous reset while a write is in flight and overflow is set.
      do_reset();
      thr = 4'd8;
      step(1, 0, 0, 4'd0, 0);
      step(0, 0, 1, 4'd2, 0);
      step(0, 0, 1, 4'd9, 1);
      step(0, 0, 1, 4'd10, 0);
      chk("pre_rst_inc", w_inc, 1);
      chk("pre_rst_ovf", ovf, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_inc", w_inc, 0);
      chk("async_rst_ovf", ovf, 0);
      chk("async_rst_status", {done, busy, armed}, 0);
      @(negedge clk);
      rst = 1'b0;

`ifdef TRIG_SLOPE_EN
      // Falling slope latched at arm: 12, 9, 7 across threshold 8 triggers on 7.
      do_reset();
      thr = 4'd8; falling = 1'b1;
      step(1, 0, 0, 4'd0, 0);
      falling = 1'b0;
      step(0, 0, 1, 4'd12, 0);
      step(0, 0, 1, 4'd9, 0);
      chk("fall_not_yet", armed, 1);
      step(0, 0, 1, 4'd7, 0);
      chk("fall_busy", busy, 1);
      chk("fall_data", w_data, 7);
      step(0, 1, 0, 4'd0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
